// File: rtl/g726_pkg.sv
// Shared G.726 definitions for the scale factor adaptation datapath.
// Holds the fixed word widths, the scale factor limits and initial value,
// and the 32 kbit/s FUNCTW log-domain weight table.
package g726_pkg;

  localparam int Y_W  = 13;  // YU and Y
  localparam int YL_W = 19;  // YL
  localparam int AL_W = 7;   // speed control AL
  localparam int I_W  = 4;   // ADPCM codeword

  localparam logic [Y_W-1:0]  YU_MIN  = 13'd544;
  localparam logic [Y_W-1:0]  YU_MAX  = 13'd5120;
  localparam logic [YL_W-1:0] YL_INIT = 19'd34816;

  // WI as a 12-bit two's complement value, indexed by the magnitude code IM.
  function automatic logic [11:0] wi_lookup(input logic [2:0] im);
    logic [11:0] wi;
    case (im)
      3'd0:    wi = 12'd4084;  // -12
      3'd1:    wi = 12'd18;
      3'd2:    wi = 12'd41;
      3'd3:    wi = 12'd64;
      3'd4:    wi = 12'd112;
      3'd5:    wi = 12'd198;
      3'd6:    wi = 12'd355;
      default: wi = 12'd1122;
    endcase
    return wi;
  endfunction

endpackage

// File: rtl/scal_fac_mix.sv
// MIX: blends the fast (YU) and slow (YL) scale factors under speed control
// AL into the quantizer scale factor Y. Purely combinational; shared with
// the inverse-quantizer path.
//   yu  in  13  fast scale factor
//   yl  in  19  slow scale factor
//   al  in  7   speed control, values above 64 act as 64
//   y   out 13  mixed scale factor
module scal_fac_mix
  import g726_pkg::*;
(
  input  logic [Y_W-1:0]  yu,
  input  logic [YL_W-1:0] yl,
  input  logic [AL_W-1:0] al,
  output logic [Y_W-1:0]  y
);

  logic [AL_W-1:0] ale;
  logic [Y_W-1:0]  yl_sh;
  logic [13:0]     dif;
  logic            difs;
  logic [13:0]     difm;
  logic [20:0]     prod_full;
  logic [13:0]     prod;
  logic            unused_bits;

  assign ale   = (al > 7'd64) ? 7'd64 : al;
  assign yl_sh = yl[YL_W-1:6];

  // 16384 vanishes modulo 2^14, so DIF is the plain 14-bit difference.
  assign dif  = {1'b0, yu} - {1'b0, yl_sh};
  assign difs = dif[13];
  assign difm = difs ? (14'd0 - dif) : dif;

  // Sign-magnitude product: magnitude scaled, then the sign reapplied,
  // which truncates toward zero for negative differences.
  assign prod_full = {7'd0, difm} * {14'd0, ale};
  assign prod      = difs ? (14'd0 - prod_full[19:6]) : prod_full[19:6];

  assign y = yl_sh + prod[Y_W-1:0];

  assign unused_bits = &{1'b0, yl[5:0], prod_full[20], prod_full[5:0], prod[13]};

endmodule

// File: rtl/quan_scal_fac_adap.sv
// Quantizer scale factor adaptation (G.726, 32 kbit/s, single channel).
// Keeps the fast scale factor YU and slow scale factor YL, and drives the
// mixed scale factor Y combinationally from the state and AL.
//   clk        in  1   rising-edge clock
//   reset      in  1   synchronous active-high, loads YU=544, YL=34816
//   scan_en    in  1   DFT scan enable (stitched at synthesis)
//   scan_in0   in  1   DFT scan input (stitched at synthesis)
//   scan_out0  out 1   DFT scan output, 0 in RTL
//   i_valid    in  1   apply i and update state on this edge
//   i          in  4   ADPCM codeword (sign [3], magnitude [2:0])
//   al         in  7   speed control AL
//   y          out 13  mixed scale factor
//   yu         out 13  fast scale factor state
//   yl         out 19  slow scale factor state
module quan_scal_fac_adap
  import g726_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             scan_en,
  input  logic             scan_in0,
  output logic             scan_out0,
  input  logic             i_valid,
  input  logic [I_W-1:0]   i,
  input  logic [AL_W-1:0]  al,
  output logic [Y_W-1:0]   y,
  output logic [Y_W-1:0]   yu,
  output logic [YL_W-1:0]  yl
);

  // LIMB: YUT never reaches a wrapped large value, so an unsigned clamp
  // covers both the lower and upper limit.
  function automatic logic [Y_W-1:0] limb(input logic [Y_W-1:0] yut);
    logic [Y_W-1:0] r;
    if (yut < YU_MIN)      r = YU_MIN;
    else if (yut > YU_MAX) r = YU_MAX;
    else                   r = yut;
    return r;
  endfunction

  logic [2:0]      im;
  logic [11:0]     wi;
  logic [16:0]     filtd_dif;
  logic [Y_W-1:0]  filtd_difsx;
  logic [Y_W-1:0]  yut;
  logic [Y_W-1:0]  yup;
  logic [19:0]     yl_neg;
  logic [13:0]     filte_dif;
  logic [YL_W-1:0] filte_difsx;
  logic [YL_W-1:0] ylp;
  logic            unused_bits;

  assign scan_out0   = 1'b0;
  assign unused_bits = &{1'b0, scan_en, scan_in0, filtd_dif[4:0], yl_neg[5:0]};

  scal_fac_mix u_mix (
    .yu (yu),
    .yl (yl),
    .al (al),
    .y  (y)
  );

  // FUNCTW: negative codewords map via 15-i, i.e. the inverted low bits.
  assign im = i[3] ? ~i[2:0] : i[2:0];
  assign wi = wi_lookup(im);

  // FILTD: YU moves 1/32 of the way from Y toward WI<<5.
  assign filtd_dif   = {wi, 5'd0} - {4'd0, y};
  assign filtd_difsx = {filtd_dif[16], filtd_dif[16:5]};
  assign yut         = y + filtd_difsx;
  assign yup         = limb(yut);

  // FILTE: YL moves 1/64 of the way toward YUP<<6.
  assign yl_neg      = 20'd0 - {1'b0, yl};
  assign filte_dif   = {1'b0, yup} + yl_neg[19:6];
  assign filte_difsx = {{(YL_W-14){filte_dif[13]}}, filte_dif};
  assign ylp         = yl + filte_difsx;

  always_ff @(posedge clk) begin
    if (reset) begin
      yu <= YU_MIN;
      yl <= YL_INIT;
    end else if (i_valid) begin
      yu <= yup;
      yl <= ylp;
    end
  end

endmodule

// File: tb/tb_quan_scal_fac_adap.sv
module tb_quan_scal_fac_adap;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        scan_en = 1'b0;
  logic        scan_in0 = 1'b0;
  logic        scan_out0;
  logic        i_valid = 1'b0;
  logic [3:0]  i = 4'd0;
  logic [6:0]  al = 7'd0;
  logic [12:0] y;
  logic [12:0] yu;
  logic [18:0] yl;

  int checks = 0;
  int failures = 0;
  int m_yu = 544;
  int m_yl = 34816;

  quan_scal_fac_adap dut (
    .clk       (clk),
    .reset     (reset),
    .scan_en   (scan_en),
    .scan_in0  (scan_in0),
    .scan_out0 (scan_out0),
    .i_valid   (i_valid),
    .i         (i),
    .al        (al),
    .y         (y),
    .yu        (yu),
    .yl        (yl)
  );

  always #5 clk = ~clk;

  // Reference model in plain integer arithmetic.
  function automatic int m_mix(input int myu, input int myl, input int a);
    int ale, ysh;
    ale = (a > 64) ? 64 : a;
    ysh = myl / 64;
    // Y = YL/64 + (YU - YL/64)*AL/64, quotient truncated toward zero
    return (ysh + ((myu - ysh) * ale) / 64) & 8191;
  endfunction

  function automatic int m_wi(input int code);
    int tbl[8] = '{-12, 18, 41, 64, 112, 198, 355, 1122};
    return tbl[(code >= 8) ? 15 - code : code];
  endfunction

  task automatic m_next(input int code, input int a, output int nyu, output int nyl);
    int my, yut;
    my  = m_mix(m_yu, m_yl, a);
    // YU = Y + floor((WI*32 - Y)/32), then limited to 544..5120
    yut = (my + ((m_wi(code) * 32 - my) >>> 5)) & 8191;
    nyu = (yut < 544) ? 544 : (yut > 5120) ? 5120 : yut;
    // YL = YL + YUP - ceil(YL/64)
    nyl = (m_yl + nyu + ((-m_yl) >>> 6)) & 524287;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive, check combinational y, clock, check state.
  task automatic step(input logic r, input logic v, input logic [3:0] code, input logic [6:0] a);
    int nyu, nyl;
    reset = r; i_valid = v; i = code; al = a;
    #1;
    chk("y_comb", 32'(y), 32'(m_mix(m_yu, m_yl, int'(a))));
    m_next(int'(code), int'(a), nyu, nyl);
    @(posedge clk);
    if (r) begin
      m_yu = 544; m_yl = 34816;
    end else if (v) begin
      m_yu = nyu; m_yl = nyl;
    end
    #1;
    chk("yu", 32'(yu), 32'(m_yu));
    chk("yl", 32'(yl), 32'(m_yl));
  endtask

  task automatic do_reset();
    reset = 1'b1; i_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_yu = 544; m_yl = 34816;
  endtask

  initial begin
    int prev;
    logic [12:0] y64;

    // Reset state
    do_reset();
    chk("rst_yu", 32'(yu), 32'd544);
    chk("rst_yl", 32'(yl), 32'd34816);
    chk("rst_scan_out0", 32'(scan_out0), 32'd0);
    al = 7'd0;  #1; chk("rst_y_al0", 32'(y), 32'd544);
    al = 7'd64; #1; chk("rst_y_al64", 32'(y), 32'd544);
    al = 7'd127; #1; chk("rst_y_al127", 32'(y), 32'd544);

    // Smallest weight clamps at the lower limit
    step(1'b0, 1'b1, 4'd0, 7'd64);
    chk("i0_yu", 32'(yu), 32'd544);
    chk("i0_yl", 32'(yl), 32'd34816);
    do_reset();
    step(1'b0, 1'b1, 4'd15, 7'd64);
    chk("i15_yu", 32'(yu), 32'd544);
    chk("i15_yl", 32'(yl), 32'd34816);

    // Largest weight, both signs
    for (int k = 0; k < 2; k++) begin
      do_reset();
      step(1'b0, 1'b1, (k == 0) ? 4'd7 : 4'd8, 7'd64);
      chk("i7_yu", 32'(yu), 32'd1649);
      chk("i7_yl", 32'(yl), 32'd35921);
      i_valid = 1'b0;
      al = 7'd64; #1; chk("i7_y_al64", 32'(y), 32'd1649);
      al = 7'd0;  #1; chk("i7_y_al0", 32'(y), 32'd561);
    end

    // Rise to the upper limit
    do_reset();
    prev = 544;
    for (int n = 0; n < 200; n++) begin
      step(1'b0, 1'b1, 4'd7, 7'd64);
      checks++;
      assert (int'(yu) >= prev && int'(yu) <= 5120) else begin
        failures++;
        $error("FAIL rise_monotonic observed=%0d expected=%0d..5120", yu, prev);
      end
      prev = int'(yu);
      #1; chk("rise_y_eq_yu", 32'(y), 32'(yu));
    end
    chk("sat_yu", 32'(yu), 32'd5120);

    // Decay to the lower limit
    for (int n = 0; n < 200; n++) begin
      step(1'b0, 1'b1, 4'd0, 7'd64);
      checks++;
      assert (int'(yu) <= prev && int'(yu) >= 544) else begin
        failures++;
        $error("FAIL decay_monotonic observed=%0d expected=544..%0d", yu, prev);
      end
      prev = int'(yu);
    end
    chk("floor_yu", 32'(yu), 32'd544);

    // Random stream with occasional holds and resets; AL spans 0..127
    do_reset();
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)), 7'($urandom_range(0, 127)));
    end

    // AL above 64 behaves as 64 on a non-trivial state
    do_reset();
    for (int n = 0; n < 6; n++) step(1'b0, 1'b1, 4'($urandom_range(4, 7)), 7'd20);
    for (int n = 0; n < 3; n++) step(1'b0, 1'b1, 4'd1, 7'd20);
    i_valid = 1'b0;
    al = 7'd64;  #1; y64 = y;
    chk("al64_model", 32'(y64), 32'(m_mix(m_yu, m_yl, 64)));
    al = 7'd100; #1; chk("al100_eq_al64", 32'(y), 32'(y64));

    // Hold with i_valid low for any codeword
    prev = int'(yu);
    for (int n = 0; n < 10; n++) step(1'b0, 1'b0, 4'($urandom_range(0, 15)), 7'd64);
    chk("hold_yu", 32'(yu), 32'(prev));

    // Reset in the middle of a burst overrides the pending update
    for (int n = 0; n < 5; n++) step(1'b0, 1'b1, 4'd7, 7'd64);
    step(1'b1, 1'b1, 4'd7, 7'd64);
    chk("midrst_yu", 32'(yu), 32'd544);
    chk("midrst_yl", 32'(yl), 32'd34816);
    reset = 1'b0; i_valid = 1'b0; #1;
    chk("midrst_y", 32'(y), 32'd544);
    chk("scan_out0", 32'(scan_out0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
